// File: rtl/i2c_target_rx.sv
// Write-only I2C target: receives bytes addressed to TARGET_ADDR, ACKs them,
// and stretches SCL while the single-entry holding register is still occupied.
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_first,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, STRETCH, DATA_ACK, IGNORE
  } state_t;

  state_t     state, state_next;
  logic       scl_meta, scl_s, scl_d;
  logic       sda_meta, sda_s, sda_d;
  logic [2:0] cnt, cnt_next;
  logic [7:0] shift, shift_next;
  logic       byte_done, byte_done_next;
  logic       first, first_next;
  logic       sda_oe_next, scl_oe_next;
  logic       load;
  logic       start_cond, stop_cond, scl_rise, scl_fall;

  // Synchronizers reset to 1 so an idle bus is assumed out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_meta <= 1'b1;
      scl_s    <= 1'b1;
      scl_d    <= 1'b1;
      sda_meta <= 1'b1;
      sda_s    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_meta <= scl_in;
      scl_s    <= scl_meta;
      scl_d    <= scl_s;
      sda_meta <= sda_in;
      sda_s    <= sda_meta;
      sda_d    <= sda_s;
    end
  end

  assign start_cond = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_cond  = scl_s & scl_d & ~sda_d & sda_s;
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    shift_next     = shift;
    byte_done_next = byte_done;
    first_next     = first;
    sda_oe_next    = sda_oe;
    scl_oe_next    = scl_oe;
    load           = 1'b0;
    if (start_cond) begin
      state_next     = ADDR;
      cnt_next       = 3'd0;
      byte_done_next = 1'b0;
      sda_oe_next    = 1'b0;
      scl_oe_next    = 1'b0;
    end else if (stop_cond) begin
      state_next     = IDLE;
      byte_done_next = 1'b0;
      sda_oe_next    = 1'b0;
      scl_oe_next    = 1'b0;
    end else begin
      case (state)
        ADDR, DATA: begin
          if (scl_rise) begin
            shift_next = {shift[6:0], sda_s};
            cnt_next   = cnt + 3'd1;
            if (cnt == 3'd7) byte_done_next = 1'b1;
          end else if (scl_fall && byte_done) begin
            // Decisions wait for the fall after bit 8 so SDA only moves while SCL is low.
            byte_done_next = 1'b0;
            if (state == DATA) begin
              state_next = STRETCH;
            end else if (shift[7:1] == TARGET_ADDR && !shift[0]) begin
              sda_oe_next = 1'b1;
              state_next  = ADDR_ACK;
            end else begin
              state_next = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_next = 1'b0;
            first_next  = 1'b1;
            state_next  = DATA;
          end
        end
        STRETCH: begin
          if (!rx_valid || rx_ready) begin
            load        = 1'b1;
            first_next  = 1'b0;
            sda_oe_next = 1'b1;
            scl_oe_next = 1'b0;
            state_next  = DATA_ACK;
          end else begin
            scl_oe_next = 1'b1;
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_next = 1'b0;
            state_next  = DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      shift     <= 8'h00;
      byte_done <= 1'b0;
      first     <= 1'b0;
      sda_oe    <= 1'b0;
      scl_oe    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      shift     <= shift_next;
      byte_done <= byte_done_next;
      first     <= first_next;
      sda_oe    <= sda_oe_next;
      scl_oe    <= scl_oe_next;
    end
  end

  // A load in the same cycle as a consume keeps rx_valid high with the new byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
    end else if (load) begin
      rx_data  <= shift;
      rx_valid <= 1'b1;
      rx_first <= first;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench: a bus master model drives open-drain SCL/SDA against the target.
module tb_i2c_target_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       rx_ready = 1'b0;
  logic       scl_oe, sda_oe, rx_valid, rx_first, busy;
  logic [7:0] rx_data;
  logic       scl_line, sda_line;

  int total = 0;
  int bad = 0;

  int         valid_cycles = 0;
  int         scl_oe_cycles = 0;
  int         sda_oe_cycles = 0;
  int         consumed = 0;
  logic [7:0] last_consumed = 8'h00;
  logic       last_first = 1'b0;

  assign scl_line = scl_drv & ~scl_oe;
  assign sda_line = sda_drv & ~sda_oe;

  i2c_target_rx #(.TARGET_ADDR(7'h50)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_line), .sda_in(sda_line),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_first(rx_first), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bus activity counters used for whole-frame properties.
  always @(posedge clk) begin
    if (rx_valid) valid_cycles <= valid_cycles + 1;
    if (scl_oe) scl_oe_cycles <= scl_oe_cycles + 1;
    if (sda_oe) sda_oe_cycles <= sda_oe_cycles + 1;
    if (rx_valid && rx_ready) begin
      consumed      <= consumed + 1;
      last_consumed <= rx_data;
      last_first    <= rx_first;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_scl_high();
    for (int i = 0; i < 500 && !scl_line; i++) tick(1);
    check_output("scl_high", {31'd0, scl_line}, 32'd1);
  endtask

  task automatic send_start();
    sda_drv = 1'b1;
    tick(4);
    scl_drv = 1'b1;
    wait_scl_high();
    tick(8);
    sda_drv = 1'b0;
    tick(8);
    scl_drv = 1'b0;
    tick(4);
  endtask

  task automatic send_stop();
    sda_drv = 1'b0;
    tick(4);
    scl_drv = 1'b1;
    wait_scl_high();
    tick(8);
    sda_drv = 1'b1;
    tick(8);
  endtask

  task automatic write_bit(input logic b);
    sda_drv = b;
    tick(4);
    scl_drv = 1'b1;
    wait_scl_high();
    tick(8);
    scl_drv = 1'b0;
    tick(4);
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
  endtask

  task automatic read_ack(output logic ack);
    sda_drv = 1'b1;
    tick(4);
    scl_drv = 1'b1;
    wait_scl_high();
    tick(4);
    ack = ~sda_line;
    tick(4);
    scl_drv = 1'b0;
    tick(4);
  endtask

  initial begin
    logic ack;
    int   v0, s0, d0, c0;

    // Reset values
    tick(3);
    check_output("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check_output("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_output("rst_rx_first", {31'd0, rx_first}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check_output("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    rst = 1'b1;
    tick(5);

    // Write 0xA0 then 0x3C with consumer always ready
    rx_ready = 1'b1;
    v0 = valid_cycles; s0 = scl_oe_cycles; c0 = consumed;
    send_start();
    check_output("w_busy", {31'd0, busy}, 32'd1);
    write_byte(8'hA0);
    read_ack(ack);
    check_output("w_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h3C);
    read_ack(ack);
    check_output("w_data_ack", {31'd0, ack}, 32'd1);
    send_stop();
    check_output("w_busy_idle", {31'd0, busy}, 32'd0);
    check_output("w_consumed", consumed - c0, 32'd1);
    check_output("w_data", {24'd0, last_consumed}, 32'h3C);
    check_output("w_first", {31'd0, last_first}, 32'd1);
    check_output("w_valid_pulse", valid_cycles - v0, 32'd1);
    check_output("w_no_stretch", scl_oe_cycles - s0, 32'd0);
    check_output("w_rx_data", {24'd0, rx_data}, 32'h3C);

    // Foreign address 0x51: no ACK anywhere in the frame
    v0 = valid_cycles; d0 = sda_oe_cycles;
    send_start();
    write_byte(8'hA2);
    read_ack(ack);
    check_output("na_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h5A);
    read_ack(ack);
    check_output("na_data_ack", {31'd0, ack}, 32'd0);
    check_output("na_busy", {31'd0, busy}, 32'd1);
    send_stop();
    check_output("na_busy_idle", {31'd0, busy}, 32'd0);
    check_output("na_sda_quiet", sda_oe_cycles - d0, 32'd0);
    check_output("na_no_valid", valid_cycles - v0, 32'd0);

    // Read request to own address is NACKed
    v0 = valid_cycles; d0 = sda_oe_cycles;
    send_start();
    write_byte(8'hA1);
    read_ack(ack);
    check_output("rd_nack", {31'd0, ack}, 32'd0);
    send_stop();
    check_output("rd_sda_quiet", sda_oe_cycles - d0, 32'd0);
    check_output("rd_no_valid", valid_cycles - v0, 32'd0);

    // Two bytes with consumer stalled: second byte stretches SCL
    rx_ready = 1'b0;
    send_start();
    write_byte(8'hA0);
    read_ack(ack);
    check_output("st_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h11);
    read_ack(ack);
    check_output("st_b1_ack", {31'd0, ack}, 32'd1);
    check_output("st_b1_valid", {31'd0, rx_valid}, 32'd1);
    check_output("st_b1_data", {24'd0, rx_data}, 32'h11);
    check_output("st_b1_first", {31'd0, rx_first}, 32'd1);
    write_byte(8'h22);
    check_output("st_scl_oe", {31'd0, scl_oe}, 32'd1);
    check_output("st_sda_oe", {31'd0, sda_oe}, 32'd0);
    check_output("st_hold_data", {24'd0, rx_data}, 32'h11);
    sda_drv = 1'b1;
    scl_drv = 1'b1;
    tick(10);
    check_output("st_line_low", {31'd0, scl_line}, 32'd0);
    check_output("st_still_oe", {31'd0, scl_oe}, 32'd1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check_output("st_b2_data", {24'd0, rx_data}, 32'h22);
    check_output("st_b2_valid", {31'd0, rx_valid}, 32'd1);
    check_output("st_b2_first", {31'd0, rx_first}, 32'd0);
    check_output("st_release", {31'd0, scl_oe}, 32'd0);
    check_output("st_ack_drive", {31'd0, sda_oe}, 32'd1);
    read_ack(ack);
    check_output("st_b2_ack", {31'd0, ack}, 32'd1);
    send_stop();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check_output("st_drained", {31'd0, rx_valid}, 32'd0);

    // Repeated START mid-byte discards the partial byte
    send_start();
    write_byte(8'hA0);
    read_ack(ack);
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    check_output("rs_no_valid", {31'd0, rx_valid}, 32'd0);
    send_start();
    write_byte(8'hA0);
    read_ack(ack);
    check_output("rs_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h55);
    read_ack(ack);
    check_output("rs_data_ack", {31'd0, ack}, 32'd1);
    send_stop();
    check_output("rs_data", {24'd0, rx_data}, 32'h55);
    check_output("rs_valid", {31'd0, rx_valid}, 32'd1);
    check_output("rs_first", {31'd0, rx_first}, 32'd1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;

    // Reset asserted while stretching releases both lines at once
    send_start();
    write_byte(8'hA0);
    read_ack(ack);
    write_byte(8'h11);
    read_ack(ack);
    write_byte(8'h22);
    check_output("rr_stretching", {31'd0, scl_oe}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check_output("rr_scl_oe", {31'd0, scl_oe}, 32'd0);
    check_output("rr_sda_oe", {31'd0, sda_oe}, 32'd0);
    check_output("rr_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_output("rr_rx_data", {24'd0, rx_data}, 32'h00);
    check_output("rr_rx_first", {31'd0, rx_first}, 32'd0);
    check_output("rr_busy", {31'd0, busy}, 32'd0);
    sda_drv = 1'b1;
    scl_drv = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(10);
    check_output("rr_idle_after", {31'd0, busy}, 32'd0);
    send_start();
    write_byte(8'hA0);
    read_ack(ack);
    check_output("rr_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h3C);
    read_ack(ack);
    send_stop();
    check_output("rr_data", {24'd0, rx_data}, 32'h3C);
    check_output("rr_first", {31'd0, rx_first}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 Parameter: TARGET_ADDR, default 7'h50, 7-bit address this target answers to.
REQ-002 Port: clk  input  1  system clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low; asserting it immediately forces the reset state.
REQ-004 Port: scl_in  input  1  raw SCL line level; the block synchronizes it internally.
REQ-005 Port: sda_in  input  1  raw SDA line level; the block synchronizes it internally.
REQ-006 Port: scl_oe  output  1  1 = pull SCL low (clock stretch); 0 = release.
REQ-007 Port: sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
REQ-008 Port: rx_data  output  8  last received data byte.
REQ-009 Port: rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-010 Port: rx_ready  input  1  consumer accepts rx_data when rx_valid=1.
REQ-011 Port: rx_first  output  1  rx_data is the first byte after the address; valid while rx_valid=1.
REQ-012 Port: busy  output  1  1 when the FSM is not in IDLE.

Function
REQ-013 scl_in and sda_in pass through 2-flop synchronizers; all edge and level decisions use the synchronized values (scl_s, sda_s) and their 1-cycle-delayed copies.
REQ-014 Condition definitions: START = sda_s falls while scl_s=1; STOP = sda_s rises while scl_s=1; SCL rise/fall = scl_s edge.
REQ-015 FSM states: IDLE, ADDR, ADDR_ACK, DATA, STRETCH, DATA_ACK, IGNORE.
REQ-016 START in any state: go to ADDR, clear the bit counter, release sda_oe and scl_oe; a repeated START is handled the same way.
REQ-017 STOP in any state: go to IDLE and release sda_oe and scl_oe; rx_data and rx_valid are unchanged.
REQ-018 In ADDR and DATA: shift sda_s into an 8-bit shift register MSB-first on each SCL rise; a 3-bit counter wraps 7->0 on the 8th bit.
REQ-019 ADDR after 8 bits, matching: if shift[7:1]==TARGET_ADDR and shift[0]==0 (write), set sda_oe=1 on the next SCL fall and enter ADDR_ACK.
REQ-020 ADDR after 8 bits, not matching: if the address mismatches or the R/W bit is 1, enter IGNORE; no ACK; sda_oe and scl_oe stay 0 until the next START or STOP.
REQ-021 ADDR_ACK: hold sda_oe=1 through the ACK clock; on the following SCL fall, release sda_oe, set first-byte flag=1, enter DATA.
REQ-022 DATA after 8 bits: on the next SCL fall, enter STRETCH.
REQ-023 STRETCH, holding register free: if rx_valid=0, or rx_valid=1 and rx_ready=1 in that cycle, load rx_data=shift, rx_valid=1, rx_first=first-byte flag, clear the flag, set sda_oe=1, and keep scl_oe=0; enter DATA_ACK.
REQ-024 STRETCH, holding register occupied: otherwise set scl_oe=1 and remain in STRETCH; scl_oe deasserts in the same cycle the load occurs.
REQ-025 DATA_ACK: hold sda_oe=1 until the next SCL fall, then release it and return to DATA.
REQ-026 rx_valid handshake: rx_valid clears when rx_valid=1 and rx_ready=1, unless a load occurs in the same cycle; load takes priority and rx_valid stays 1 with the new byte.
REQ-027 sda_oe and scl_oe change only in the cycles named above and are registered outputs; sda_oe never changes while scl_s=1 except on START or STOP.
REQ-028 busy = (state != IDLE).
REQ-029 Block never transmits data; a read request is always NACKed (released SDA).

Reset
REQ-030 On rst=0: state=IDLE, counter=0, shift=0, first-byte flag=0, scl_oe=0, sda_oe=0, rx_data=8'h00, rx_valid=0, rx_first=0, busy=0; synchronizers load 1 (idle bus).
REQ-031 Reset mid-transfer: releases both lines within the same cycle reset asserts; after deassertion the block waits for a new START.

Verification
REQ-032 Write 0xA0 then data 0x3C, rx_ready=1 -> ACK on the address and data; rx_data=0x3C, rx_valid pulses, rx_first=1, scl_oe never asserted.
REQ-033 Address 0xA2 (0x51) -> sda_oe stays 0 for the whole frame; state IGNORE until STOP; busy=0 after STOP.
REQ-034 Read request 0xA1 -> NACK; no rx_valid.
REQ-035 Two bytes 0x11, 0x22 with rx_ready=0 -> byte 1 loaded and ACKed; after byte 2 scl_oe=1 until rx_ready=1; then rx_data=0x22 in the same cycle, scl_oe=0, rx_first=0.
REQ-036 Repeated START mid-data, then 0xA0 and 0x55 -> partial byte discarded; 0x55 delivered with rx_first=1.
REQ-037 rst=0 while scl_oe=1 in STRETCH -> scl_oe=0 and sda_oe=0 immediately; all outputs at reset values.
